// File: rtl/numden_mac_sched.sv
// -----------------------------------------------------------------------------
// numden_mac_sched
//   Time-multiplexed scheduler for the LPC numerator/denominator dot products
//     Rn = sum_k R_num[k]*a[k],  Rd = sum_k R_den[k]*a[k],  k = 0..ORDER
//   The index is walked through an external register file with a 1-cycle read
//   latency. Two 16x16 signed products are accumulated per fetched term. The
//   narrowed results are registered and flagged with a 1-cycle vout pulse.
//
//   FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE. abort returns to IDLE from any
//   busy state without publishing a result.
//
// Parameters
//   ORDER : highest coefficient index (ORDER+1 terms per product)
//   IW    : index width, >= clog2(ORDER+1)
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   asynchronous, active-low reset
//   start   in   start a computation (sampled only in IDLE)
//   abort   in   synchronous cancel of the running computation
//   busy    out  high in every state except IDLE
//   rd_en   out  register-file read strobe
//   rd_idx  out  register-file read index (holds when rd_en=0)
//   r_num   in   signed R_num[rd_idx], valid 1 cycle after rd_en
//   r_den   in   signed R_den[rd_idx], valid 1 cycle after rd_en
//   a_k     in   signed a[rd_idx], valid 1 cycle after rd_en
//   Rn      out  signed numerator result, held between completions
//   Rd      out  signed denominator result, held between completions
//   vout    out  1-cycle pulse when Rn/Rd update
//
// Configuration macro
//   NUMDEN_SAT_EN : when defined, narrowing of the accumulators to 32 bits
//                   saturates; otherwise it is a plain two's-complement wrap.
// -----------------------------------------------------------------------------
module numden_mac_sched #(
    parameter int ORDER = 10,
    parameter int IW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 rd_en,
    output logic [IW-1:0]        rd_idx,
    input  logic signed [15:0]   r_num,
    input  logic signed [15:0]   r_den,
    input  logic signed [15:0]   a_k,
    output logic signed [31:0]   Rn,
    output logic signed [31:0]   Rd,
    output logic                 vout
);

    // Guard bits so that ORDER+1 full-scale products can never overflow.
    localparam int AW = 32 + $clog2(ORDER + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(ORDER);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_reg;
    logic                  rd_vld_reg;
    logic signed [AW-1:0]  acc_n_reg;
    logic signed [AW-1:0]  acc_d_reg;

    logic signed [31:0]    prod_n;
    logic signed [31:0]    prod_d;
    logic signed [31:0]    narrow_n;
    logic signed [31:0]    narrow_d;

    // Operands are sign-extended to 32 bits; the low 32 bits of the product
    // are the exact signed 16x16 result.
    assign prod_n = $signed({{16{r_num[15]}}, r_num}) * $signed({{16{a_k[15]}}, a_k});
    assign prod_d = $signed({{16{r_den[15]}}, r_den}) * $signed({{16{a_k[15]}}, a_k});

`ifdef NUMDEN_SAT_EN
    // In range when all bits from 31 upwards agree with the sign bit.
    function automatic logic [31:0] sat32(input logic signed [AW-1:0] v);
        if ((&v[AW-1:31]) || !(|v[AW-1:31]))
            return v[31:0];
        else if (v[AW-1])
            return 32'h8000_0000;
        else
            return 32'h7FFF_FFFF;
    endfunction

    assign narrow_n = sat32(acc_n_reg);
    assign narrow_d = sat32(acc_d_reg);
`else
    assign narrow_n = acc_n_reg[31:0];
    assign narrow_d = acc_d_reg[31:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            busy       <= 1'b0;
            rd_en      <= 1'b0;
            rd_idx     <= '0;
            rd_vld_reg <= 1'b0;
            acc_n_reg  <= '0;
            acc_d_reg  <= '0;
            Rn         <= '0;
            Rd         <= '0;
            vout       <= 1'b0;
        end else begin
            vout       <= 1'b0;
            rd_vld_reg <= rd_en;

            // Data returned for the previous fetch is folded in here; an abort
            // discards it so nothing partial survives the cancel.
            if (rd_vld_reg && !abort) begin
                acc_n_reg <= acc_n_reg + {{(AW-32){prod_n[31]}}, prod_n};
                acc_d_reg <= acc_d_reg + {{(AW-32){prod_d[31]}}, prod_d};
            end

            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        state_reg <= RUN;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_idx    <= '0;
                        acc_n_reg <= '0;
                        acc_d_reg <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_reg  <= IDLE;
                        busy       <= 1'b0;
                        rd_en      <= 1'b0;
                        rd_vld_reg <= 1'b0;
                    end else if (rd_idx == LAST_IDX) begin
                        // Last index was issued this cycle; its data lands in DRAIN.
                        state_reg <= DRAIN;
                        rd_en     <= 1'b0;
                    end else begin
                        rd_idx <= rd_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state_reg  <= IDLE;
                        busy       <= 1'b0;
                        rd_vld_reg <= 1'b0;
                    end else begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    if (!abort) begin
                        Rn   <= narrow_n;
                        Rd   <= narrow_d;
                        vout <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    rd_en     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_numden_mac_sched.sv
module tb_numden_mac_sched;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               busy;
    logic               rd_en;
    logic [3:0]         rd_idx;
    logic signed [15:0] r_num = '0;
    logic signed [15:0] r_den = '0;
    logic signed [15:0] a_k = '0;
    logic signed [31:0] Rn;
    logic signed [31:0] Rd;
    logic               vout;

    int n_chk  = 0;
    int n_pass = 0;

    numden_mac_sched #(.ORDER(10), .IW(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .busy   (busy),
        .rd_en  (rd_en),
        .rd_idx (rd_idx),
        .r_num  (r_num),
        .r_den  (r_den),
        .a_k    (a_k),
        .Rn     (Rn),
        .Rd     (Rd),
        .vout   (vout)
    );

    always #5 clk = ~clk;

    // External register file: 1-cycle read latency.
    logic signed [15:0] rn_mem [0:15];
    logic signed [15:0] rd_mem [0:15];
    logic signed [15:0] a_mem  [0:15];

    always @(posedge clk) begin
        if (rd_en) begin
            r_num <= rn_mem[rd_idx];
            r_den <= rd_mem[rd_idx];
            a_k   <= a_mem[rd_idx];
        end
    end

    // Per-term value = base + step*k
    typedef struct {
        string name;
        int    rn0, rns, rd0, rds, a0, a_st;
        int    exp_rn, exp_rd;
    } vec_t;

    vec_t vecs [0:4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic load(input vec_t v);
        for (int k = 0; k < 16; k++) begin
            rn_mem[k] = 16'(v.rn0 + v.rns * k);
            rd_mem[k] = 16'(v.rd0 + v.rds * k);
            a_mem[k]  = 16'(v.a0 + v.a_st * k);
        end
    endtask

    // Runs one computation; optionally re-pulses start at cycle restart_at.
    task automatic do_run(input string nm, input int restart_at);
        int lat;
        int nidx;
        int nvout;
        bit seq_ok;
        bit busy_ok;
        lat = 0; nidx = 0; nvout = 0; seq_ok = 1'b1; busy_ok = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!vout && lat < 40) begin
            if (rd_en) begin
                if (rd_idx !== 4'(nidx)) seq_ok = 1'b0;
                nidx++;
            end
            if (!busy) busy_ok = 1'b0;
            start = (lat == restart_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (nidx != 11) seq_ok = 1'b0;
        chk({nm, " latency"}, 32'(lat), 32'd13);
        chk({nm, " rd_idx seq"}, 32'(seq_ok), 32'd1);
        chk({nm, " busy during run"}, 32'(busy_ok), 32'd1);
        chk({nm, " busy at vout"}, 32'(busy), 32'd0);
        if (vout) nvout = 1;
        repeat (5) begin
            @(negedge clk);
            if (vout) nvout++;
        end
        chk({nm, " vout count"}, 32'(nvout), 32'd1);
        $display("run %s: lat=%0d Rn=%0d Rd=%0d", nm, lat, Rn, Rd);
    endtask

    initial begin
        int waited;
        int nv;

        vecs[0] = '{"T1",    0,   1,  0,  2,  1, 0,     55,    110};
`ifdef NUMDEN_SAT_EN
        vecs[1] = '{"T2", -32768, 0, -32768, 0, -32768, 0, 32'h7FFFFFFF, 32'h7FFFFFFF};
`else
        vecs[1] = '{"T2", -32768, 0, -32768, 0, -32768, 0, 32'hC0000000, 32'hC0000000};
`endif
        vecs[2] = '{"T3",  1000,  0, -5,  0, -3, 0, -33000,    165};
        vecs[3] = '{"SQ",     0,  1,  0, -1,  0, 1,    385,   -385};
        vecs[4] = '{"MIX",  100,-20,  1,  1,  0, 1,  -2200,    440};

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("reset busy",   32'(busy),   32'd0);
        chk("reset rd_en",  32'(rd_en),  32'd0);
        chk("reset rd_idx", 32'(rd_idx), 32'd0);
        chk("reset Rn",     Rn,          32'd0);
        chk("reset Rd",     Rd,          32'd0);
        chk("reset vout",   32'(vout),   32'd0);
        @(negedge clk); rst = 1'b1;

        // Table-driven runs
        for (int i = 0; i < 5; i++) begin
            load(vecs[i]);
            do_run(vecs[i].name, -1);
            chk({vecs[i].name, " Rn"}, Rn, 32'(vecs[i].exp_rn));
            chk({vecs[i].name, " Rd"}, Rd, 32'(vecs[i].exp_rd));
        end

        // start with abort in IDLE: stays idle
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("start+abort busy",  32'(busy),  32'd0);
        chk("start+abort rd_en", 32'(rd_en), 32'd0);
        $display("start+abort in IDLE: busy=%0d", busy);

        // T4: extra start mid-run is ignored
        load(vecs[4]);
        do_run("T4", 5);
        chk("T4 Rn", Rn, 32'(-2200));

        // T5: abort at rd_idx=6
        load(vecs[0]);
        do_run("T5pre", -1);
        chk("T5pre Rn", Rn, 32'd55);
        load(vecs[2]);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        waited = 0;
        while (!(rd_en && rd_idx == 4'd6) && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        chk("T5 reached idx6", 32'(waited < 30), 32'd1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("T5 busy after abort",  32'(busy),  32'd0);
        chk("T5 rd_en after abort", 32'(rd_en), 32'd0);
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (vout) nv++;
        end
        chk("T5 no vout", 32'(nv), 32'd0);
        chk("T5 Rn held", Rn, 32'd55);
        chk("T5 Rd held", Rd, 32'd110);
        $display("abort T5: Rn=%0d Rd=%0d", Rn, Rd);
        do_run("T5post", -1);
        chk("T5post Rn", Rn, 32'(-33000));
        chk("T5post Rd", Rd, 32'd165);

        // T6: async reset mid-run
        load(vecs[3]);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("T6 busy",   32'(busy),   32'd0);
        chk("T6 rd_en",  32'(rd_en),  32'd0);
        chk("T6 rd_idx", 32'(rd_idx), 32'd0);
        chk("T6 Rn",     Rn,          32'd0);
        chk("T6 Rd",     Rd,          32'd0);
        chk("T6 vout",   32'(vout),   32'd0);
        $display("async reset T6: busy=%0d Rn=%0d", busy, Rn);
        @(negedge clk); rst = 1'b1;
        do_run("T6post", -1);
        chk("T6post Rn", Rn, 32'd385);
        chk("T6post Rd", Rd, 32'(-385));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
